candy_opfetch: RTL and testbench
================================

CANDY_OPFETCH -- requirements
Module: candy_opfetch

Interface
REQ-001 Parameters SHALL be: DW default 32, data width matching `RegBus and `SRAMDataWidth; AW default 10, SRAM address width; RW default 5, register address width; OPW default 4, opcode width.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  instruction accepted this cycle when in_valid is also high.
- in_op  in  OPW  opcode, passed through.
- in_a_is_mem, in_b_is_mem  in  1 each  operand source: 1 = SRAM, 0 = register.
- in_a_addr, in_b_addr  in  AW each  operand address; register sources use bits [RW-1:0].
- in_b_used  in  1  operand B is present.
- in_dst_addr  in  AW  destination address, passed through.
- in_dst_is_mem  in  1  destination kind, passed through.
- rf_raddr_a, rf_raddr_b  out  RW each  register-file read addresses.
- rf_rdata_a, rf_rdata_b  in  DW each  register-file read data, combinational.
- sram_read_enable  out  1  SRAM read strobe.
- sram_raddr  out  AW  SRAM read address.
- sram_rdata  in  DW  SRAM read data, valid the cycle after the strobe.
- wb_reg_we, wb_reg_waddr, wb_reg_wdata  in  1/RW/DW  writeback register write, used for bypass.
- wb_sram_we, wb_sram_waddr, wb_sram_wdata  in  1/AW/DW  writeback SRAM write, used for bypass.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  consumer accepts.
- out_a, out_b  out  DW each  fetched operands.
- out_op, out_dst_addr, out_dst_is_mem  out  OPW/AW/1  passthrough fields.

Function
REQ-003 The FSM SHALL have six states: IDLE, REQ_A, CAP_A, REQ_B, CAP_B, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; acceptance occurs when in_valid and in_ready are both 1.
REQ-005 On acceptance the block SHALL latch in_op, in_dst_addr, in_dst_is_mem, both source descriptors and in_b_used.
REQ-006 On acceptance the block SHALL latch each register operand from rf_rdata_x, with rf_raddr_x driven from in_x_addr[RW-1:0].
- If wb_reg_we is 1 and wb_reg_waddr matches in that cycle, wb_reg_wdata SHALL be latched instead.
REQ-007 On acceptance the next state SHALL be:
- REQ_A if A is mem;
- else REQ_B if in_b_used and B is mem;
- else DONE.
REQ-008 REQ_A SHALL assert sram_read_enable with sram_raddr equal to the A address, then go to CAP_A.
REQ-009 CAP_A SHALL latch sram_rdata into out_a.
- If B is used and mem, CAP_A SHALL also assert sram_read_enable with the B address and go to CAP_B.
- Otherwise CAP_A SHALL go to DONE.
REQ-010 REQ_B SHALL assert the read for the B address and go to CAP_B; CAP_B SHALL latch sram_rdata into out_b and go to DONE.
REQ-011 The SRAM is read-first, so SRAM bypass SHALL apply.
- Condition: wb_sram_we is 1 with wb_sram_waddr equal to the operand address, in that operand's issue cycle or capture cycle.
- Action: wb_sram_wdata SHALL be captured, with capture-cycle data taking precedence over issue-cycle data.
REQ-012 In states other than IDLE, a wb_reg_we write matching a latched register operand's address SHALL overwrite that operand.
REQ-013 DONE SHALL hold out_valid at 1 and all outputs stable until out_ready is 1, then go to IDLE; in_ready SHALL remain 0 in DONE.
REQ-014 When in_b_used is 0, out_b SHALL be 0.
REQ-015 Latency from the acceptance edge to out_valid SHALL be:
- 1 cycle with no mem operands;
- 3 cycles with exactly one mem operand;
- 4 cycles with two mem operands.
REQ-016 sram_read_enable SHALL be 0 in IDLE and DONE; rf_raddr_x SHALL follow in_x_addr at all times.

Reset
REQ-017 While rst is 0 the block SHALL asynchronously force:
- state to IDLE;
- out_valid, sram_read_enable, sram_raddr, out_a, out_b, out_op, out_dst_addr and out_dst_is_mem to 0;
- all latched fields to 0.
REQ-018 Reset during any non-IDLE state SHALL abandon the instruction with no further SRAM reads; in_ready SHALL be 1 on the first edge after rst returns high.

Verification
REQ-019 Register/register case: rf r3=0x11, r4=0x22; accept A=reg3, B=reg4 -> out_valid next cycle with out_a=0x11, out_b=0x22, and no SRAM read.
REQ-020 Memory/memory case: SRAM[0x010]=0xAA, SRAM[0x020]=0xBB; accept A=mem 0x010, B=mem 0x020.
- Required: reads to 0x010 then 0x020 on consecutive cycles.
- Required: out_valid 4 cycles after acceptance with out_a=0xAA, out_b=0xBB.
REQ-021 Register bypass: rf r5=1 and wb writes r5=0x55 in the acceptance cycle -> out_a=0x55.
- Variant: wb writes r5 while the block waits in CAP_B -> out_a=0x55.
REQ-022 SRAM bypass: wb writes SRAM[0x010]=0x77 in A's issue cycle -> out_a=0x77 regardless of sram_rdata.
REQ-023 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-024 Reset: rst pulled low during CAP_A -> out_valid=0 and sram_read_enable=0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/candy_opfetch.sv
// candy_opfetch: operand fetch stage. Accepts one decoded instruction,
// gathers operand A and B from the register file or the read-first SRAM
// (with writeback bypass on both paths) and presents the bundle until
// the consumer takes it.
//
// state | meaning
// IDLE  | ready for a new instruction, register operands latched on accept
// REQ_A | SRAM read strobe for operand A
// CAP_A | capture A from SRAM; issue B read when B is a used mem operand
// REQ_B | SRAM read strobe for operand B (A was a register)
// CAP_B | capture B from SRAM
// DONE  | bundle valid, held until out_ready
module candy_opfetch #(
  parameter int DW  = 32,
  parameter int AW  = 10,
  parameter int RW  = 5,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic           in_a_is_mem,
  input  logic           in_b_is_mem,
  input  logic [AW-1:0]  in_a_addr,
  input  logic [AW-1:0]  in_b_addr,
  input  logic           in_b_used,
  input  logic [AW-1:0]  in_dst_addr,
  input  logic           in_dst_is_mem,
  output logic [RW-1:0]  rf_raddr_a,
  output logic [RW-1:0]  rf_raddr_b,
  input  logic [DW-1:0]  rf_rdata_a,
  input  logic [DW-1:0]  rf_rdata_b,
  output logic           sram_read_enable,
  output logic [AW-1:0]  sram_raddr,
  input  logic [DW-1:0]  sram_rdata,
  input  logic           wb_reg_we,
  input  logic [RW-1:0]  wb_reg_waddr,
  input  logic [DW-1:0]  wb_reg_wdata,
  input  logic           wb_sram_we,
  input  logic [AW-1:0]  wb_sram_waddr,
  input  logic [DW-1:0]  wb_sram_wdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [OPW-1:0] out_op,
  output logic [AW-1:0]  out_dst_addr,
  output logic           out_dst_is_mem
);

  typedef enum logic [2:0] {IDLE, REQ_A, CAP_A, REQ_B, CAP_B, DONE} state_t;

  state_t          state_q, state_d;
  logic            a_is_mem_q, b_is_mem_q, b_used_q;
  logic [AW-1:0]   a_addr_q, b_addr_q;
  logic            byp_hit_q;
  logic [DW-1:0]   byp_data_q;

  logic [DW-1:0]   acc_a_val, acc_b_val;
  logic            a_reg_hit, b_reg_hit, a_sram_hit, b_sram_hit;
  logic            b_mem_used_q;

  assign rf_raddr_a = in_a_addr[RW-1:0];
  assign rf_raddr_b = in_b_addr[RW-1:0];
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);

  // Register values as seen at acceptance, with same-cycle writeback forwarded.
  assign acc_a_val = (wb_reg_we && wb_reg_waddr == in_a_addr[RW-1:0]) ? wb_reg_wdata : rf_rdata_a;
  assign acc_b_val = (wb_reg_we && wb_reg_waddr == in_b_addr[RW-1:0]) ? wb_reg_wdata : rf_rdata_b;

  assign b_mem_used_q = b_used_q && b_is_mem_q;
  assign a_reg_hit  = wb_reg_we && !a_is_mem_q && (wb_reg_waddr == a_addr_q[RW-1:0]);
  assign b_reg_hit  = wb_reg_we && b_used_q && !b_is_mem_q && (wb_reg_waddr == b_addr_q[RW-1:0]);
  assign a_sram_hit = wb_sram_we && (wb_sram_waddr == a_addr_q);
  assign b_sram_hit = wb_sram_we && (wb_sram_waddr == b_addr_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and SRAM read strobe.
  always_comb begin
    state_d          = state_q;
    sram_read_enable = 1'b0;
    sram_raddr       = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_a_is_mem)                  state_d = REQ_A;
          else if (in_b_used && in_b_is_mem) state_d = REQ_B;
          else                               state_d = DONE;
        end
      end
      REQ_A: begin
        sram_read_enable = 1'b1;
        sram_raddr       = a_addr_q;
        state_d          = CAP_A;
      end
      CAP_A: begin
        if (b_mem_used_q) begin
          sram_read_enable = 1'b1;
          sram_raddr       = b_addr_q;
          state_d          = CAP_B;
        end else begin
          state_d = DONE;
        end
      end
      REQ_B: begin
        sram_read_enable = 1'b1;
        sram_raddr       = b_addr_q;
        state_d          = CAP_B;
      end
      CAP_B: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Instruction latch, operand capture and both bypass paths.
  // byp_* carries an issue-cycle SRAM write forward to the capture cycle;
  // a write in the capture cycle itself wins over it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_a          <= '0;
      out_b          <= '0;
      out_op         <= '0;
      out_dst_addr   <= '0;
      out_dst_is_mem <= 1'b0;
      a_is_mem_q     <= 1'b0;
      b_is_mem_q     <= 1'b0;
      b_used_q       <= 1'b0;
      a_addr_q       <= '0;
      b_addr_q       <= '0;
      byp_hit_q      <= 1'b0;
      byp_data_q     <= '0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        out_op         <= in_op;
        out_dst_addr   <= in_dst_addr;
        out_dst_is_mem <= in_dst_is_mem;
        a_is_mem_q     <= in_a_is_mem;
        b_is_mem_q     <= in_b_is_mem;
        b_used_q       <= in_b_used;
        a_addr_q       <= in_a_addr;
        b_addr_q       <= in_b_addr;
        out_a          <= in_a_is_mem ? '0 : acc_a_val;
        out_b          <= (in_b_used && !in_b_is_mem) ? acc_b_val : '0;
        byp_hit_q      <= 1'b0;
        byp_data_q     <= '0;
      end
    end else begin
      if (a_reg_hit) out_a <= wb_reg_wdata;
      if (b_reg_hit) out_b <= wb_reg_wdata;
      case (state_q)
        REQ_A: begin
          byp_hit_q  <= a_sram_hit;
          byp_data_q <= wb_sram_wdata;
        end
        CAP_A: begin
          out_a      <= a_sram_hit ? wb_sram_wdata : (byp_hit_q ? byp_data_q : sram_rdata);
          byp_hit_q  <= b_sram_hit;
          byp_data_q <= wb_sram_wdata;
        end
        REQ_B: begin
          byp_hit_q  <= b_sram_hit;
          byp_data_q <= wb_sram_wdata;
        end
        CAP_B: begin
          out_b <= b_sram_hit ? wb_sram_wdata : (byp_hit_q ? byp_data_q : sram_rdata);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_candy_opfetch.sv
// Bench for candy_opfetch: register file and read-first SRAM environment,
// directed scenarios plus random instructions with writeback traffic,
// scoreboard of expected bundles checked by an independent monitor.
module tb_candy_opfetch;
  localparam int DW = 32, AW = 10, RW = 5, OPW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid, in_ready;
  logic [OPW-1:0] in_op;
  logic           in_a_is_mem, in_b_is_mem, in_b_used, in_dst_is_mem;
  logic [AW-1:0]  in_a_addr, in_b_addr, in_dst_addr;
  logic [RW-1:0]  rf_raddr_a, rf_raddr_b;
  logic [DW-1:0]  rf_rdata_a, rf_rdata_b;
  logic           sram_read_enable;
  logic [AW-1:0]  sram_raddr;
  logic [DW-1:0]  sram_rdata = '0;
  logic           wb_reg_we, wb_sram_we;
  logic [RW-1:0]  wb_reg_waddr;
  logic [AW-1:0]  wb_sram_waddr;
  logic [DW-1:0]  wb_reg_wdata, wb_sram_wdata;
  logic           out_valid, out_ready, out_dst_is_mem;
  logic [DW-1:0]  out_a, out_b;
  logic [OPW-1:0] out_op;
  logic [AW-1:0]  out_dst_addr;

  candy_opfetch #(.DW(DW), .AW(AW), .RW(RW), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a_is_mem(in_a_is_mem), .in_b_is_mem(in_b_is_mem),
    .in_a_addr(in_a_addr), .in_b_addr(in_b_addr), .in_b_used(in_b_used),
    .in_dst_addr(in_dst_addr), .in_dst_is_mem(in_dst_is_mem),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .sram_read_enable(sram_read_enable), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .wb_reg_we(wb_reg_we), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
    .wb_sram_we(wb_sram_we), .wb_sram_waddr(wb_sram_waddr), .wb_sram_wdata(wb_sram_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op),
    .out_dst_addr(out_dst_addr), .out_dst_is_mem(out_dst_is_mem)
  );

  typedef struct {
    logic a_mem, b_mem, b_used, dst_mem;
    logic [AW-1:0] a_addr, b_addr, dst;
    logic [OPW-1:0] op;
    int hold;
    logic [3:0] rw, sw;
    logic [3:0][RW-1:0] rwa;
    logic [3:0][AW-1:0] swa;
    logic [3:0][DW-1:0] rwd, swd;
  } txn_t;

  typedef struct {
    logic [DW-1:0] a, b;
    logic [OPW-1:0] op;
    logic [AW-1:0] dst;
    logic dst_mem;
    int lat, t0, hold, nrd;
    logic [AW-1:0] rd0, rd1;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  logic [DW-1:0] rf  [32];
  logic [DW-1:0] mem [1024];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM read port: strobe observed mid-cycle, data returned after the edge.
  logic          rd_en_s = 1'b0;
  logic [AW-1:0] rd_addr_s = '0;
  logic [AW-1:0] rd_log[$];
  int            rd_cyc[$];
  always @(negedge clk) begin
    rd_en_s   <= sram_read_enable;
    rd_addr_s <= sram_raddr;
    if (sram_read_enable) begin
      rd_log.push_back(sram_raddr);
      rd_cyc.push_back(cyc);
    end
  end
  always @(posedge clk) if (rd_en_s) sram_rdata <= mem[rd_addr_s];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_now();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Writes seen by the DUT at the previous edge land in the arrays here,
  // so reads in the same cycle as a write return old data.
  task automatic tick();
    @(negedge clk);
    if (wb_reg_we)  rf[wb_reg_waddr]   = wb_reg_wdata;
    if (wb_sram_we) mem[wb_sram_waddr] = wb_sram_wdata;
  endtask

  function automatic int lat_of(txn_t t);
    int nm = int'(t.a_mem) + int'(t.b_used && t.b_mem);
    return (nm == 0) ? 1 : (nm == 1) ? 3 : 4;
  endfunction

  // Operand value = newest write to its location up to its capture cycle.
  function automatic logic [DW-1:0] reg_val(txn_t t, logic [RW-1:0] a, int kmax);
    logic [DW-1:0] v = rf[a];
    for (int k = 0; k <= kmax; k++) if (t.rw[k] && t.rwa[k] == a) v = t.rwd[k];
    return v;
  endfunction

  function automatic logic [DW-1:0] mem_val(txn_t t, logic [AW-1:0] a, int kmax);
    logic [DW-1:0] v = mem[a];
    for (int k = 0; k <= kmax; k++) if (t.sw[k] && t.swa[k] == a) v = t.swd[k];
    return v;
  endfunction

  function automatic exp_t model(txn_t t);
    exp_t e;
    e.lat = lat_of(t); e.op = t.op; e.dst = t.dst; e.dst_mem = t.dst_mem;
    e.hold = t.hold; e.nrd = 0; e.rd0 = '0; e.rd1 = '0; e.t0 = 0;
    if (t.a_mem) begin
      e.a = mem_val(t, t.a_addr, 2); e.rd0 = t.a_addr; e.nrd = 1;
    end else e.a = reg_val(t, t.a_addr[RW-1:0], e.lat - 1);
    if (!t.b_used) e.b = '0;
    else if (t.b_mem) begin
      e.b = mem_val(t, t.b_addr, t.a_mem ? 3 : 2);
      if (e.nrd == 0) e.rd0 = t.b_addr; else e.rd1 = t.b_addr;
      e.nrd++;
    end else e.b = reg_val(t, t.b_addr[RW-1:0], e.lat - 1);
    return e;
  endfunction

  function automatic txn_t mk(logic am, logic [AW-1:0] aa, logic bu, logic bm, logic [AW-1:0] ba);
    txn_t t;
    t.a_mem = am; t.a_addr = aa; t.b_used = bu; t.b_mem = bm; t.b_addr = ba;
    t.op = OPW'($urandom); t.dst = AW'($urandom); t.dst_mem = 1'($urandom_range(0, 1));
    t.hold = 0; t.rw = '0; t.sw = '0; t.rwa = '0; t.swa = '0; t.rwd = '0; t.swd = '0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    logic am = 1'($urandom_range(0, 1));
    logic bm = 1'($urandom_range(0, 1));
    logic [AW-1:0] aa = am ? AW'($urandom_range(0, 15)) : AW'(($urandom_range(0, 31) << RW) | $urandom_range(0, 7));
    logic [AW-1:0] ba = bm ? AW'($urandom_range(0, 15)) : AW'(($urandom_range(0, 31) << RW) | $urandom_range(0, 7));
    t = mk(am, aa, 1'($urandom_range(0, 3) != 0), bm, ba);
    t.hold = $urandom_range(0, 3);
    for (int k = 0; k < 4; k++) begin
      t.rw[k] = ($urandom_range(0, 2) == 0); t.rwa[k] = RW'($urandom_range(0, 7)); t.rwd[k] = $urandom;
      t.sw[k] = ($urandom_range(0, 2) == 0); t.swa[k] = AW'($urandom_range(0, 15)); t.swd[k] = $urandom;
    end
    return t;
  endfunction

  task automatic drive_wb(txn_t t, int k);
    wb_reg_we  = t.rw[k]; wb_reg_waddr  = t.rwa[k]; wb_reg_wdata  = t.rwd[k];
    wb_sram_we = t.sw[k]; wb_sram_waddr = t.swa[k]; wb_sram_wdata = t.swd[k];
  endtask

  task automatic wb_off();
    wb_reg_we = 1'b0; wb_sram_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready) begin
      tick();
      n++;
      if (n > 60) begin
        n_fail++;
        $display("FAIL wait_idle: in_ready still 0 after %0d cycles", n);
        finish_now();
      end
    end
  endtask

  task automatic accept(txn_t t);
    in_valid = 1'b1; in_op = t.op; in_a_is_mem = t.a_mem; in_b_is_mem = t.b_mem;
    in_a_addr = t.a_addr; in_b_addr = t.b_addr; in_b_used = t.b_used;
    in_dst_addr = t.dst; in_dst_is_mem = t.dst_mem;
  endtask

  task automatic scramble();
    in_valid = 1'b0; in_op = OPW'($urandom); in_a_addr = AW'($urandom); in_b_addr = AW'($urandom);
    in_a_is_mem = 1'($urandom_range(0, 1)); in_b_is_mem = 1'($urandom_range(0, 1));
    in_b_used = 1'($urandom_range(0, 1)); in_dst_addr = AW'($urandom);
    in_dst_is_mem = 1'($urandom_range(0, 1));
  endtask

  task automatic run_txn(txn_t t);
    exp_t e;
    int lat;
    wait_idle();
    lat = lat_of(t);
    e = model(t);
    e.t0 = cyc;
    sb.push_back(e);
    accept(t);
    drive_wb(t, 0);
    for (int k = 1; k < lat; k++) begin
      tick();
      scramble();
      drive_wb(t, k);
      if (k == 1) chk("in_ready_busy", in_ready, 1'b0);
    end
    tick();
    scramble();
    wb_off();
  endtask

  // Monitor / consumer: pops an expectation per bundle, applies backpressure.
  initial begin
    exp_t e;
    logic busy = 1'b0, released = 1'b0;
    int cnt = 0;
    logic [DW-1:0] sa = '0, sbv = '0;
    logic [OPW-1:0] sop = '0;
    logic [AW-1:0] sdst = '0;
    logic sdm = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (released) begin
        chk("idle_after_hs_valid", out_valid, 1'b0);
        chk("idle_after_hs_ready", in_ready, 1'b1);
        released = 1'b0;
        out_ready = 1'b0;
      end
      if (out_valid) begin
        if (!busy) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_valid: out_valid 1 with no pending instruction");
          end else begin
            e = sb.pop_front();
            chk("out_a", out_a, e.a);
            chk("out_b", out_b, e.b);
            chk("out_op", out_op, e.op);
            chk("out_dst_addr", out_dst_addr, e.dst);
            chk("out_dst_is_mem", out_dst_is_mem, e.dst_mem);
            chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            chk("rd_count", 64'(rd_log.size()), 64'(e.nrd));
            if (rd_log.size() == e.nrd) begin
              if (e.nrd >= 1) chk("rd_addr0", rd_log[0], e.rd0);
              if (e.nrd == 2) begin
                chk("rd_addr1", rd_log[1], e.rd1);
                chk("rd_consecutive", 64'(rd_cyc[1] - rd_cyc[0]), 64'd1);
              end
            end
            rd_log.delete(); rd_cyc.delete();
            cnt = e.hold; busy = 1'b1;
            sa = out_a; sbv = out_b; sop = out_op; sdst = out_dst_addr; sdm = out_dst_is_mem;
          end
        end else begin
          chk("hold_stable", {out_a, out_b, out_op, out_dst_addr, out_dst_is_mem} ==
              {sa, sbv, sop, sdst, sdm}, 1'b1);
          chk("hold_in_ready", in_ready, 1'b0);
          chk("hold_no_read", sram_read_enable, 1'b0);
        end
        if (busy) begin
          if (cnt == 0) begin
            out_ready = 1'b1; released = 1'b1; busy = 1'b0;
          end else cnt--;
        end
      end
    end
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    finish_now();
  end

  // Stimulus.
  initial begin
    txn_t t;
    rst = 1'b0;
    in_valid = 1'b0;
    scramble();
    wb_off();
    wb_reg_waddr = '0; wb_reg_wdata = '0; wb_sram_waddr = '0; wb_sram_wdata = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sram_re", {sram_read_enable, sram_raddr}, '0);
    chk("rst_outs", {out_a, out_b, out_op, out_dst_addr, out_dst_is_mem}, '0);
    rst = 1'b1;
    tick();

    rf[3] = 32'h11; rf[4] = 32'h22;
    run_txn(mk(1'b0, 10'd3, 1'b1, 1'b0, 10'd4));
    mem[10'h010] = 32'hAA; mem[10'h020] = 32'hBB;
    run_txn(mk(1'b1, 10'h010, 1'b1, 1'b1, 10'h020));
    rf[5] = 32'h1;
    t = mk(1'b0, 10'd5, 1'b0, 1'b0, 10'd0);
    t.rw[0] = 1'b1; t.rwa[0] = 5'd5; t.rwd[0] = 32'h55;
    run_txn(t);
    wait_idle();
    rf[5] = 32'h1;
    t = mk(1'b0, 10'd5, 1'b1, 1'b1, 10'h030);
    t.rw[2] = 1'b1; t.rwa[2] = 5'd5; t.rwd[2] = 32'h55;
    run_txn(t);
    mem[10'h010] = 32'h99;
    t = mk(1'b1, 10'h010, 1'b0, 1'b0, 10'd0);
    t.sw[1] = 1'b1; t.swa[1] = 10'h010; t.swd[1] = 32'h77;
    run_txn(t);
    t = mk(1'b1, 10'h040, 1'b1, 1'b0, 10'd7);
    t.hold = 5;
    run_txn(t);

    for (int i = 0; i < 150; i++) run_txn(rand_txn());

    begin
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 60) begin tick(); n++; end
      chk("drain_empty", 64'(sb.size()), 64'd0);
    end

    // Reset while in CAP_A of a mem/mem instruction.
    wait_idle();
    t = mk(1'b1, 10'h050, 1'b1, 1'b1, 10'h060);
    accept(t);
    tick(); scramble();
    tick();
    chk("pre_rst_re", {sram_read_enable, sram_raddr}, {1'b1, 10'h060});
    #1 rst = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_re", sram_read_enable, 1'b0);
    tick(); tick();
    rst = 1'b1;
    rd_log.delete(); rd_cyc.delete();
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    tick(); tick(); tick();
    chk("post_rst_no_reads", 64'(rd_log.size()), 64'd0);
    chk("post_rst_no_valid", out_valid, 1'b0);

    finish_now();
  end

endmodule
